spi_responder: RTL
==================

// Module: spi_responder
// PURPOSE
//  SPI mode-0 target (responder) end of the team's SPI link: receives an external
//  SCLK/SS/MOSI from an off-chip or on-chip initiator, all oversampled on the local
//  clk. Deserialises MOSI into W-bit words (MSB first) and serialises local TX words
//  onto MISO. Byte-level valid/ready handshakes connect it to local logic.
// PARAMETERS
//  W           8      word width in bits (>=2)
//  DEFAULT_TX  8'hFF  word shifted out when no TX word is offered at load time
// PORTS
//  clk       in   1  system clock; sclk frequency <= clk/8
//  rst       in   1  synchronous, active-high reset
//  sclk      in   1  SPI serial clock from initiator (asynchronous to clk)
//  ss        in   1  slave select, active low (asynchronous)
//  mosi      in   1  serial data from initiator
//  miso      out  1  serial data to initiator
//  tx_data   in   W  next word to transmit
//  tx_valid  in   1  tx_data offered
//  tx_ready  out  1  high for the single clk cycle in which the TX shifter loads
//  rx_data   out  W  last complete received word
//  rx_valid  out  1  rx_data holds an unconsumed word
//  rx_ready  in   1  consumer takes rx_data when rx_valid & rx_ready
//  overrun   out  1  sticky overrun flag (present only with SPI_RESP_OVERRUN_EN)
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): miso=0, tx_ready=0, rx_valid=0, rx_data=0, overrun=0,
//    bit_cnt=0, state=IDLE, synchroniser flops cleared to sclk=0, ss=1.
//  - sclk, ss, mosi pass through 2-flop synchronisers; edges taken from synced sclk vs
//    its previous value. Pin-to-internal latency is 2 clk.
//  - States: IDLE -> LOAD -> SHIFT.
//    IDLE: miso=0. Synced ss falling -> LOAD.
//    LOAD (1 cycle): tx_ready=1; shifter <= tx_valid ? tx_data : DEFAULT_TX; bit_cnt=0;
//      miso = shifter MSB from next cycle (valid before first rising sclk). -> SHIFT.
//    SHIFT: sclk rise: rx_shift <= {rx_shift[W-2:0], mosi_s}; bit_cnt++.
//      sclk fall: shifter <<= 1, miso = new MSB; if bit_cnt==W -> LOAD (back-to-back words).
//  - Word complete on the W-th rising edge: rx_data <= {rx_shift[W-2:0], mosi_s},
//    rx_valid <= 1 in the same cycle; rx_valid visible 3 clk after the pin edge.
//  - rx_valid clears the cycle after rx_valid & rx_ready; stays set otherwise.
//    Completion coinciding with rx_ready=1: new word loads, rx_valid stays 1, no overrun.
//  - ss rising in SHIFT (any bit_cnt): abort -> IDLE next cycle; partial word discarded,
//    no rx_valid; already-loaded TX word is lost (not re-offered).
//  - ss rising and W-th rising edge in same cycle: word completes, then IDLE.
//  - tx_valid low at LOAD: DEFAULT_TX sent, tx_ready still pulses (no transfer).
//  - rst mid-frame: immediate return to reset values; initiator must re-assert ss.
// CONFIGURATION
//  SPI_RESP_OVERRUN_EN defined: word completing while rx_valid=1 and rx_ready=0 sets
//    overrun (sticky until rst); rx_data is overwritten with the newer word.
//  Undefined: no overrun port or logic; newer word silently overwrites rx_data.
// STRUCTURE
//  spi_pkg: state enum (IDLE/LOAD/SHIFT), SYNC_STAGES=2 constant, shared SPI mode
//    constants used by both spi ends.
//  Sub-module spi_sync_edge: 2-flop synchroniser + rise/fall detect; one instance each
//    for sclk and ss, mosi via plain synchroniser instance (edges unused).
// TESTING  (W=8, DEFAULT_TX=8'hFF, sclk = clk/8)
//  1. rst, ss low, tx_data=8'h3C tx_valid=1, initiator sends 8'hA5 -> MISO 0,0,1,1,1,1,0,0;
//     rx_data=8'hA5, rx_valid=1; tx_ready pulsed exactly once.
//  2. Two back-to-back words 8'h11, 8'h22, tx_valid=0, rx_ready=1 -> MISO 8'hFF twice;
//     two rx_valid events with rx_data 8'h11 then 8'h22.
//  3. ss raised after 5 bits of 8'hC3 -> no rx_valid; next frame 8'h5A received as 8'h5A.
//  4. rx_ready held 0, words 8'h01 then 8'h02 -> rx_data=8'h02; overrun=1 with
//     SPI_RESP_OVERRUN_EN, port absent without; rx_ready on completion cycle -> no overrun.
//  5. rst asserted at bit 4 -> next cycle miso=0, rx_valid=0, tx_ready=0, state IDLE;
//     following full frame 8'h96 received correctly.
//  6. ss rise in same cycle as 8th rising edge of 8'h7E -> rx_data=8'h7E, rx_valid=1, IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions for both link ends: FSM encodings, synchroniser depth
// and the bus mode (CPOL/CPHA) the link runs in.
package spi_pkg;

  localparam int SYNC_STAGES = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;
  localparam bit SS_IDLE  = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall pulses taken
// from the synchronised level against its value one clk earlier.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   level_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain <= {SYNC_STAGES{RESET_VAL}};
      level_prev <= RESET_VAL;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], din};
      level_prev <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign level = sync_chain[SYNC_STAGES-1];
  assign rise  = level & ~level_prev;
  assign fall  = ~level & level_prev;

endmodule

// File: rtl/spi_responder.sv
// SPI target end: oversamples SCLK/SS/MOSI on clk, deserialises RX words and
// serialises TX words MSB first. Define SPI_RESP_OVERRUN_EN for the sticky overrun flag.
module spi_responder
  import spi_pkg::*;
#(
  parameter int           W          = 8,
  parameter logic [W-1:0] DEFAULT_TX = W'(8'hFF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sclk,
  input  logic         ss,
  input  logic         mosi,
  output logic         miso,
  input  logic [W-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [W-1:0] rx_data,
  output logic         rx_valid,
  input  logic         rx_ready
`ifdef SPI_RESP_OVERRUN_EN
  ,
  output logic         overrun
`endif
);

  localparam int             CW             = $clog2(W + 1);
  localparam logic [CW-1:0]  LAST_BIT       = CW'(W - 1);
  localparam logic [CW-1:0]  FULL           = CW'(W);
  localparam bit             SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

  logic [1:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [W-1:0]  tx_shift;
  logic [W-1:0]  rx_shift;
  logic [W-1:0]  load_word;

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic sample, shift_out, word_done;
  logic unused;

  spi_sync_edge #(.RESET_VAL(SPI_CPOL)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(SS_IDLE)) u_ss_sync (
    .clk(clk), .rst(rst), .din(ss),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .din(mosi),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign sample    = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
  assign shift_out = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;
  assign word_done = (state == SHIFT) && sample && (bit_cnt == LAST_BIT);
  assign load_word = tx_valid ? tx_data : DEFAULT_TX;
  assign tx_ready  = (state == LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      miso     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (ss_fall) state <= LOAD;
        end
        LOAD: begin
          tx_shift <= load_word;
          miso     <= load_word[W-1];
          bit_cnt  <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (sample) begin
            rx_shift <= {rx_shift[W-2:0], mosi_s};
            bit_cnt  <= bit_cnt + 1'b1;
          end
          // A completing word wins over a same-cycle consume: rx_valid stays set.
          if (word_done) begin
            rx_data  <= {rx_shift[W-2:0], mosi_s};
            rx_valid <= 1'b1;
          end
          if (shift_out) begin
            tx_shift <= {tx_shift[W-2:0], 1'b0};
            miso     <= tx_shift[W-2];
            if (bit_cnt == FULL) state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
      // Deselect overrides any pending reload; the loaded TX word is dropped.
      if (ss_rise && (state != IDLE)) begin
        state <= IDLE;
        miso  <= 1'b0;
      end
    end
  end

`ifdef SPI_RESP_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst) overrun <= 1'b0;
    else if (word_done && rx_valid && !rx_ready) overrun <= 1'b1;
  end
`endif

  assign unused = ^{sclk_level, ss_level, mosi_rise, mosi_fall,
                    tx_shift[W-1], rx_shift[W-1]};

endmodule
